instr_sequencer: RTL

//  Multi-cycle sequencer for the processor datapath. Steps each instruction through

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_wait_timer.sv | 36 +++
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer.
//   state_e  : sequencer FSM states
//   ctl_t    : control-word fields that must survive past DECODE
//   PC_SEL_* : encodings of the pc_sel output
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_EXWAIT,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERROR
  } state_e;

  // halt/nop are consumed in DECODE itself, so they are not kept here.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic jump;
    logic jr;
    logic jal;
    logic branch;
    logic stack;
    logic multi;
  } ctl_t;

  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_REG    = 2'b11;

  // States that wait on an external handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM) || (s == ST_EXWAIT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-state watchdog counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : force count to zero (state change or not waiting)
//   en_i       : count this cycle
//   timeout_o  : count has reached WAIT_MAX-1
module seq_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = (cnt_q == CW'(WAIT_MAX - 1));

  // Saturate at the timeout value so the flag cannot roll back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                cnt_d = '0;
    else if (en_i && !timeout_o) cnt_d = cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/(EXWAIT)/(MEM)/WB.
// Inputs : run, imem_ready, dmem_ready, alu_done, branch_taken, ctl_* control word.
// Outputs: imem_req/ir_write (fetch), dmem_req/dmem_we/stack_en (data),
//          alu_start (mult/div), reg_write, pc_write/pc_sel, halted, error,
//          retired (instructions completed, including NOP/HALT).
// All strobes are decoded from the registered state, so an asynchronous
// reset drops them immediately.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_done,
  input  logic             branch_taken,
  input  logic             ctl_regwrite,
  input  logic             ctl_memread,
  input  logic             ctl_memwrite,
  input  logic             ctl_jump,
  input  logic             ctl_jr,
  input  logic             ctl_jal,
  input  logic             ctl_branch,
  input  logic             ctl_halt,
  input  logic             ctl_nop,
  input  logic             ctl_stack,
  input  logic             ctl_multi,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_start,
  output logic             reg_write,
  output logic             stack_en,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  ctl_t             ctl_q, ctl_in;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             timeout;

  assign ctl_in = '{regwrite: ctl_regwrite, memread: ctl_memread,
                    memwrite: ctl_memwrite, jump: ctl_jump, jr: ctl_jr,
                    jal: ctl_jal, branch: ctl_branch, stack: ctl_stack,
                    multi: ctl_multi};

  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  ((state_d != state_q) || !is_wait_state(state_q)),
    .en_i     (is_wait_state(state_q)),
    .timeout_o(timeout)
  );

  // NOTE: every output and state_d gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_start = 1'b0;
    reg_write = 1'b0;
    stack_en  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = PC_SEL_PC4;
    halted    = 1'b0;
    error     = 1'b0;

    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      // DECODE looks at the live control word; it is captured for later states.
      ST_DECODE: begin
        if (ctl_halt) begin
          state_d = ST_HALT;
        end else if (ctl_nop) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctl_q.multi) begin
          alu_start = 1'b1;
          state_d   = ST_EXWAIT;
        end else if (ctl_q.memread || ctl_q.memwrite) begin
          state_d = ST_MEM;
        end else if (ctl_q.jump) begin
          pc_write  = 1'b1;
          pc_sel    = ctl_q.jr ? PC_SEL_REG : PC_SEL_JUMP;
          reg_write = ctl_q.jal;
          state_d   = ST_FETCH;
        end else if (ctl_q.branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_EXWAIT: begin
        if (alu_done)     state_d = ST_WB;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctl_q.memwrite;
        if (dmem_ready) begin
          stack_en = ctl_q.stack;
          if (ctl_q.memwrite) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        reg_write = ctl_q.regwrite;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_ERROR: error  = 1'b1;
      default:  state_d = ST_ERROR;
    endcase
  end

  // HALT retires without a PC update, so it is counted on DECODE exit.
  always_comb begin
    retired_d = retired_q;
    if (pc_write || (state_q == ST_DECODE && ctl_halt))
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctl_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      if (state_q == ST_DECODE) ctl_q <= ctl_in;
    end
  end

  assign retired = retired_q;

endmodule
